// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, types and helpers for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    // Requester count and the width of an index into it.
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // FSM encodings, kept as plain constants so older blocks can share them.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_t;

    // Next requester index with natural 3-bit wrap (7 -> 0).
    function automatic idx_t idx_next(input idx_t i);
        return i + idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority picker: first set request bit at or after ptr (mod 8).
// Purely combinational; the arbiter registers the result.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] idx,
    output logic       any
);

    logic [2*N_REQ-1:0] req_dbl;
    req_t               rot;
    idx_t               ofs;

    // Doubling the vector turns the rotate-right into a plain part select:
    // rot[j] is requester (ptr + j) mod 8.
    assign req_dbl = {req, req};
    assign rot     = req_dbl[ptr +: N_REQ];

    // Fixed-priority encode of the rotated vector, lowest bit wins.
    always_comb begin
        // NOTE: default before the loop so every path assigns ofs (no latch).
        ofs = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                ofs = idx_t'(j);
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps modulo 8 by itself.
    assign idx = ofs + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with hold timeout.
// Drives a registered grant index plus valid into the downstream 3-to-8
// decoder. A grant is held until done, request withdrawal or MAX_HOLD
// cycles, and every grant is followed by at least one dead (IDLE) cycle so
// the decoded one-hot never moves directly from one owner to another.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,   // 2..255
    parameter int CNT_W    = 8     // 2**CNT_W > MAX_HOLD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state;
    idx_t             ptr;
    logic [CNT_W-1:0] hold_cnt;

    idx_t             pick_idx;
    logic             pick_any;

    logic             owner_req;
    logic             hold_hit;
    logic             rel_early;
    logic             release_now;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Release decode while BUSY. A voluntary release (done or withdrawal)
    // takes precedence over the hold limit for the purpose of flagging a
    // timeout, so a collision with the last hold cycle is a normal release.
    assign owner_req   = req[gnt_idx];
    assign hold_hit    = (hold_cnt == HOLD_LAST);
    assign rel_early   = done | ~owner_req;
    assign release_now = rel_early | hold_hit;

    // Grant FSM, rotation pointer, hold counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples
            // the pre-edge values, regardless of statement order.
            timeout <= 1'b0;
            if (state == S_IDLE) begin
                if (pick_any) begin
                    gnt_idx   <= pick_idx;
                    gnt_valid <= 1'b1;
                    hold_cnt  <= '0;
                    state     <= S_BUSY;
                end else begin
                    gnt_valid <= 1'b0;
                end
            end else begin
                if (release_now) begin
                    gnt_valid <= 1'b0;
                    ptr       <= idx_next(gnt_idx);
                    timeout   <= hold_hit & ~rel_early;
                    state     <= S_IDLE;
                end else begin
                    hold_cnt  <= hold_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: the driver predicts each cycle's outputs
// from a transaction-level model and queues them; the monitor pops and
// compares one entry per clock.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       tmo;
    } obs_t;

    logic       clock;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t exp_q[$];

    // Reference model: who owns the grant, how long it has been shown,
    // where the next search starts and whether a forced release just happened.
    int   m_owner;
    int   m_held;
    int   m_ptr;
    int   m_last;
    bit   m_tmo;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_tmo   = 1'b0;
    endtask

    // Advance the model by one clock with the given inputs and queue the
    // outputs that must be visible after that clock.
    task automatic model_step(input logic [7:0] r, input logic d);
        obs_t e;
        bit   found;
        bit   voluntary;
        int   c;
        if (m_owner < 0) begin
            m_tmo = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                c = (m_ptr + k) % 8;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end else begin
            voluntary = d || !r[m_owner];
            if (voluntary || m_held == MAX_HOLD) begin
                m_tmo   = !voluntary;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_tmo  = 1'b0;
                m_held = m_held + 1;
            end
        end
        e.valid = (m_owner >= 0);
        e.idx   = 3'(m_last);
        e.tmo   = m_tmo;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and record the prediction.
    task automatic step(input logic [7:0] r, input logic d);
        @(negedge clock);
        req  = r;
        done = d;
        model_step(r, d);
    endtask

    // Assert reset between edges, confirm the grant drops without a clock
    // edge, then release it with requests idle.
    task automatic mid_reset(input string name);
        @(negedge clock);
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check({name, "_async_valid"}, 32'(gnt_valid), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: one queued prediction per clock, sampled just after the edge.
    initial begin : monitor
        obs_t e;
        obs_t a;
        int   cyc = 0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{valid: gnt_valid, idx: gnt_idx, tmo: timeout};
                check($sformatf("cycle%0d {valid,idx,timeout}", cyc), 32'(a), 32'(e));
            end
        end
    end

    initial begin : driver
        logic [7:0] r;
        logic       d;

        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        #1;
        check("reset_gnt_idx",   32'(gnt_idx),   32'd0);
        check("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        check("reset_timeout",   32'(timeout),   32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset mid-grant, then idle with the pointer back at 0.
        repeat (3) step(8'h01, 1'b0);
        mid_reset("rst_mid_grant");
        repeat (2) step(8'h00, 1'b0);

        // Rotation between two persistent requesters: 0, 7, 0, 7.
        repeat (4) begin
            step(8'h81, 1'b0);
            step(8'h81, 1'b1);
        end

        // Wrap from 7: pointer back to 0, then 1, then 2.
        repeat (2) begin
            step(8'h06, 1'b0);
            step(8'h06, 1'b1);
        end

        // Forced release of a single held requester and its re-grant.
        repeat (12) step(8'h10, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Withdrawal alone, then done on the last hold cycle.
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        step(8'h04, 1'b0);
        repeat (3) step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        // Withdrawal on the last hold cycle.
        step(8'h04, 1'b0);
        repeat (3) step(8'h04, 1'b0);
        step(8'h00, 1'b0);

        // done while IDLE, and a foreign request toggling under a grant.
        repeat (3) step(8'h00, 1'b1);
        step(8'h04, 1'b0);
        step(8'h24, 1'b0);
        step(8'h04, 1'b0);
        step(8'h24, 1'b0);
        step(8'h24, 1'b1);
        step(8'h00, 1'b0);

        // Random traffic with sticky requests so timeouts still occur.
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                r = 8'($urandom & $urandom);
            end
            d = ($urandom_range(4) == 0);
            step(r, d);
            if (i == 300) begin
                mid_reset("rst_random");
                r = 8'h00;
            end
        end

        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        @(posedge clock);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
